// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register map, Status/Cause field positions,
// exception codes and the exception-level state encoding.
package cp0_pkg;

    // Register addresses
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    // Status fields
    localparam int ST_IE_BIT  = 0;
    localparam int ST_EXL_BIT = 1;
    localparam int ST_IM_LSB  = 8;

    // Cause fields
    localparam int CA_EXC_LSB = 2;
    localparam int CA_IP_LSB  = 8;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_TRAP = 5'd13;

    // Exception-level FSM; the state register is Status.EXL itself
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_IN_EXC = 1'b1;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, and a sticky
// match flag (the IP7 source) is raised when an increment lands on Compare.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter bit TIMER_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_count,
    input  logic              wr_compare,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare,
    output logic              flag
);

    logic              tog;
    logic [DATA_W-1:0] count_inc;

    assign count_inc = count + DATA_W'(1);

    // Half-rate enable: Count only moves on cycles where tog is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            tog <= 1'b0;
        else if (TIMER_EN)  tog <= ~tog;
        else                tog <= 1'b0;
    end

    // Count: a software write takes precedence over the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             count <= '0;
        else if (!TIMER_EN)  count <= '0;
        else if (wr_count)   count <= wdata;
        else if (tog)        count <= count_inc;
    end

    // Compare is plain software state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             compare <= '0;
        else if (wr_compare) compare <= wdata;
    end

    // Match flag: set on an increment reaching Compare, cleared by writing Compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        flag <= 1'b0;
        else if (!TIMER_EN)                             flag <= 1'b0;
        else if (wr_compare)                            flag <= 1'b0;
        else if (tog && !wr_count && count_inc == compare) flag <= 1'b1;
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: Status/Cause/EPC plus timer, mfc0/mtc0 access,
// exception entry / eret sequencing and a registered PC redirect pulse.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int               DATA_W     = 32,
    parameter int               ADDR_W     = 5,
    parameter int               NUM_HW_INT = 6,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h0040_0004,
    parameter bit               TIMER_EN   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_W-1:0]     CP0_R_ADDR,
    output logic [DATA_W-1:0]     CP0_RDATA,
    input  logic                  MTC0,
    input  logic [ADDR_W-1:0]     CP0_W_ADDR,
    input  logic [DATA_W-1:0]     CP0_WDATA,
    input  logic                  EXC_REQ,
    input  logic [4:0]            EXC_CODE,
    input  logic [DATA_W-1:0]     EXC_PC,
    input  logic                  ERET,
    input  logic [NUM_HW_INT-1:0] HW_INT,
    output logic                  INT_PENDING,
    output logic                  PC_REDIRECT,
    output logic [DATA_W-1:0]     PC_TARGET,
    output logic [DATA_W-1:0]     STATUS_OUT,
    output logic [DATA_W-1:0]     EPC_OUT
);

    logic              ie;
    logic [0:0]        exl;
    logic [7:0]        im;
    logic [4:0]        exc_code;
    logic [1:0]        ip_sw;
    logic [5:0]        ip_hw;   // Cause.IP[7:2]
    logic [5:0]        hw_vec;
    logic [DATA_W-1:0] epc;
    logic [DATA_W-1:0] tmr_count, tmr_compare;
    logic              tmr_flag;
    logic [DATA_W-1:0] status_word, cause_word;

    logic do_exc, do_eret, do_wr;
    logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;

    // EXC_REQ beats ERET beats MTC0; a losing event is dropped entirely
    assign do_exc     = EXC_REQ;
    assign do_eret    = ERET & ~EXC_REQ & (exl == ST_IN_EXC);
    assign do_wr      = MTC0 & ~EXC_REQ & ~ERET;
    assign wr_status  = do_wr && (CP0_W_ADDR == ADDR_W'(CP0_STATUS));
    assign wr_cause   = do_wr && (CP0_W_ADDR == ADDR_W'(CP0_CAUSE));
    assign wr_epc     = do_wr && (CP0_W_ADDR == ADDR_W'(CP0_EPC));
    assign wr_count   = do_wr && (CP0_W_ADDR == ADDR_W'(CP0_COUNT));
    assign wr_compare = do_wr && (CP0_W_ADDR == ADDR_W'(CP0_COMPARE));

    cp0_timer #(.DATA_W(DATA_W), .TIMER_EN(TIMER_EN)) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .wr_count   (wr_count),
        .wr_compare (wr_compare),
        .wdata      (CP0_WDATA),
        .count      (tmr_count),
        .compare    (tmr_compare),
        .flag       (tmr_flag)
    );

    // Hardware interrupt lines padded to six, timer folded onto IP7
    always_comb begin
        hw_vec                   = '0;
        hw_vec[NUM_HW_INT-1:0]   = HW_INT;
        hw_vec[5]                = hw_vec[5] | tmr_flag;
    end

    // Status: exception entry/return own EXL, otherwise software writes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ie  <= 1'b0;
            exl <= ST_NORMAL;
            im  <= '0;
        end else if (do_exc) begin
            exl <= ST_IN_EXC;
        end else if (do_eret) begin
            exl <= ST_NORMAL;
        end else if (wr_status) begin
            ie  <= CP0_WDATA[ST_IE_BIT];
            exl <= CP0_WDATA[ST_EXL_BIT];
            im  <= CP0_WDATA[ST_IM_LSB +: 8];
        end
    end

    // Cause: ExcCode on exception, IP[1:0] by software, IP[7:2] sampled every cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exc_code <= EXC_INT;
            ip_sw    <= '0;
            ip_hw    <= '0;
        end else begin
            ip_hw <= hw_vec;
            if (do_exc)        exc_code <= EXC_CODE;
            else if (wr_cause) ip_sw    <= CP0_WDATA[CA_IP_LSB +: 2];
        end
    end

    // EPC: captured only on first-level entry so nested faults keep the original return PC
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                            epc <= '0;
        else if (do_exc && exl == ST_NORMAL) epc <= EXC_PC;
        else if (wr_epc)                    epc <= CP0_WDATA;
    end

    // Registered one-cycle redirect toward the handler or back to EPC
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC_REDIRECT <= 1'b0;
            PC_TARGET   <= '0;
        end else begin
            PC_REDIRECT <= do_exc | do_eret;
            if (do_exc)       PC_TARGET <= EXC_VECTOR;
            else if (do_eret) PC_TARGET <= epc;
        end
    end

    // Architectural views of Status and Cause; unimplemented bits read 0
    always_comb begin
        status_word                  = '0;
        status_word[ST_IE_BIT]       = ie;
        status_word[ST_EXL_BIT]      = exl[0];
        status_word[ST_IM_LSB +: 8]  = im;
        cause_word                   = '0;
        cause_word[CA_EXC_LSB +: 5]  = exc_code;
        cause_word[CA_IP_LSB +: 8]   = {ip_hw, ip_sw};
    end

    // mfc0 read mux, pre-edge state only
    always_comb begin
        case (CP0_R_ADDR)
            ADDR_W'(CP0_COUNT):   CP0_RDATA = tmr_count;
            ADDR_W'(CP0_COMPARE): CP0_RDATA = tmr_compare;
            ADDR_W'(CP0_STATUS):  CP0_RDATA = status_word;
            ADDR_W'(CP0_CAUSE):   CP0_RDATA = cause_word;
            ADDR_W'(CP0_EPC):     CP0_RDATA = epc;
            default:              CP0_RDATA = '0;
        endcase
    end

    assign INT_PENDING = ie & ~exl[0] & (|({ip_hw, ip_sw} & im));
    assign STATUS_OUT  = status_word;
    assign EPC_OUT     = epc;

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Parametrised coprocessor-0 for the multi-cycle MIPS core; replaces the stand-alone CP0 read-address mux with a full register file.
- Holds Count, Compare, Status, Cause and EPC, serves mfc0/mtc0, sequences exception entry and eret, and raises a registered PC-redirect pulse for the control FSM.
- Sits beside the main register file; the controller samples INT_PENDING and drives EXC_REQ.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 5, CP0 register address width
NUM_HW_INT, 6, external interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2]
EXC_VECTOR, 32'h0040_0004, handler entry address
TIMER_EN, 1, 1 = Count/Compare timer on IP7; 0 = Count held at 0, IP7 tied 0

Ports:
CLK  in  1  clock
RST  in  1  reset
CP0_R_ADDR  in  ADDR_W  mfc0 read address
CP0_RDATA  out  DATA_W  read data
MTC0  in  1  write enable
CP0_W_ADDR  in  ADDR_W  mtc0 address
CP0_WDATA  in  DATA_W  mtc0 data
EXC_REQ  in  1  exception request, one cycle
EXC_CODE  in  5  ExcCode (0 int, 8 syscall, 9 break, 13 trap)
EXC_PC  in  DATA_W  faulting/interrupted PC
ERET  in  1  exception return, one cycle
HW_INT  in  NUM_HW_INT  level interrupt inputs
INT_PENDING  out  1  interrupt should be taken
PC_REDIRECT  out  1  one-cycle redirect pulse
PC_TARGET  out  DATA_W  redirect address, valid with PC_REDIRECT
STATUS_OUT  out  DATA_W  Status
EPC_OUT  out  DATA_W  EPC

Behaviour:
- One clock CLK; reset RST is asynchronous, active-high.
- Reset values: Count 0, Compare 0, Status 0 (IE=0, EXL=0, IM=0), Cause 0, EPC 0, PC_REDIRECT 0, PC_TARGET 0. CP0_RDATA and INT_PENDING are therefore 0 out of reset.
- Register map:
  - 9 Count
  - 11 Compare
  - 12 Status: IE bit0, EXL bit1, IM[15:8]
  - 13 Cause: ExcCode[6:2], IP[15:8]
  - 14 EPC
  - Other addresses read 0; writes to them are ignored.
- Read: combinational from CP0_R_ADDR, showing pre-edge state. No same-cycle write bypass.
- Write: Status writes only IE, EXL and IM; other bits read 0. Cause writes only IP[1:0] (software interrupts). Count, Compare and EPC write the full word.
- Cause.IP[7:2] is registered each cycle from HW_INT and the timer flag; unused lines read 0.
- Timer (TIMER_EN=1):
  - Count increments every second cycle via an internal toggle and wraps 0xFFFF_FFFF to 0.
  - When Count==Compare after an increment, the timer flag (IP7) sets and stays set until Compare is written.
  - An mtc0 to Count overrides the increment in that cycle.
- INT_PENDING = IE & ~EXL & |(IP & IM), combinational from registered state.
- FSM has two states, NORMAL (EXL=0) and IN_EXC (EXL=1).
  - EXC_REQ in NORMAL: EPC<=EXC_PC, ExcCode<=EXC_CODE, EXL<=1, go to IN_EXC.
  - EXC_REQ in IN_EXC (nested): ExcCode updated, EPC unchanged, redirect still issued.
  - ERET in IN_EXC: EXL<=0, go to NORMAL, PC_TARGET=EPC.
  - ERET in NORMAL: ignored, no redirect.
- Redirect latency: request sampled at edge N; PC_REDIRECT is high for exactly the cycle after edge N. PC_TARGET is EXC_VECTOR for an exception, or EPC (value before edge N) for eret.
- Same-cycle priority: EXC_REQ > ERET > MTC0.
  - A lower-priority event is dropped in full.
  - Exception: MTC0 to EPC or Status in the same cycle as EXC_REQ is discarded.
  - Timer and IP sampling continue regardless of these events.
- RST asserted mid-operation: all state clears immediately and any pending redirect pulse is cancelled.

Decomposition:
- Package cp0_pkg holds:
  - register address constants (9, 11, 12, 13, 14)
  - Status/Cause bit-position constants
  - ExcCode constants
  - the FSM state encoding
- One sub-module, cp0_timer, owns Count, Compare, the toggle and the IP7 flag. It has a write port and exposes its count and flag.

Test Plan:
- Reset: RST high mid-count → next cycle all outputs 0; read addr 12 → 0; PC_REDIRECT 0.
- mtc0 Status = 0x0000_0401 then HW_INT[0]=1 → Cause reads 0x0000_0400; INT_PENDING=1 one cycle after HW_INT rises.
- EXC_REQ code 8, EXC_PC 0x0040_0100 → next cycle PC_REDIRECT=1, PC_TARGET=0x0040_0004; EPC=0x0040_0100; Cause=0x20; Status.EXL=1; INT_PENDING=0.
- Nested EXC_REQ code 9, PC 0x0040_0200 while EXL=1 → EPC stays 0x0040_0100, ExcCode=9. ERET → PC_TARGET=0x0040_0100, EXL=0. A second ERET → no redirect.
- Timer: Compare=10, Count=0, IM7=1, IE=1 → IP7 and INT_PENDING set about 20 cycles later. Writing Compare clears IP7. Count=0xFFFF_FFFF wraps to 0.
- Collision: EXC_REQ + ERET + MTC0 to EPC (0xDEAD_0000) in one cycle → exception path taken, EPC=EXC_PC, mtc0 discarded.
